// File: rtl/bcd_mod_counter.sv
// ---------------------------------------------------------------------------
// bcd_mod_counter
//   Modulo-(L+1) up/down counter for the clock/timer datapath (seconds,
//   minutes, hours, countdown digits). L = min(limit, 99). Supports a
//   synchronous preload, wrap or stop-at-terminal behaviour, a registered
//   one-cycle carry/borrow pulse and a two-digit BCD view of the count.
//   A stage's carry is meant to drive the next stage's en. All stages share
//   one clock.
//
// Parameters
//   WIDTH     : count/limit/load width, 4..7
//   RESET_VAL : count value after reset, <= 99
//   WRAP      : 1 = wrap at the terminal count, 0 = stop at the terminal
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   en       in   count enable / chain carry-in
//   up       in   1 = increment, 0 = decrement
//   load     in   synchronous preload strobe (wins over en)
//   load_val in   preload value, clamped to L
//   limit    in   terminal count, may change at any time
//   count    out  registered count
//   tens     out  BCD tens digit of count
//   ones     out  BCD ones digit of count
//   carry    out  registered one-cycle wrap/borrow pulse
//   done     out  count sits at the terminal for the current direction
//                 (stop mode only; always 0 when WRAP=1)
// ---------------------------------------------------------------------------
module bcd_mod_counter #(
  parameter int WIDTH     = 7,
  parameter int RESET_VAL = 0,
  parameter int WRAP      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             carry,
  output logic             done
);

  // All arithmetic is done in a fixed 7-bit domain so the cap at 99 is
  // expressible for every legal WIDTH. Because limit is only WIDTH bits
  // wide, the result is automatically capped at 2^WIDTH-1 for WIDTH < 7.
  localparam logic [6:0]       BCD_MAX   = 7'd99;
  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);
  localparam bit               WRAP_EN   = (WRAP != 0);

  logic [WIDTH-1:0] count_r;
  logic             carry_r;

  logic [6:0] cnt_w_s;
  logic [6:0] limit_w_s;
  logic [6:0] lim_w_s;
  logic [6:0] load_w_s;
  logic [6:0] load_clamp_s;
  logic [6:0] cnt_nxt_s;
  logic       carry_nxt_s;
  logic       done_s;
  logic [7:0] bcd_s;

  // Split a 0..99 binary value into {tens, ones} BCD digits.
  function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 7'd10);
    o = 4'(v - (7'(t) * 7'd10));
    return {t, o};
  endfunction

  assign cnt_w_s      = 7'(count_r);
  assign limit_w_s    = 7'(limit);
  assign lim_w_s      = (limit_w_s > BCD_MAX) ? BCD_MAX : limit_w_s;
  assign load_w_s     = 7'(load_val);
  assign load_clamp_s = (load_w_s > lim_w_s) ? lim_w_s : load_w_s;

  // Next count / carry: load beats en, en beats hold.
  always_comb begin
    cnt_nxt_s   = cnt_w_s;
    carry_nxt_s = 1'b0;
    if (load) begin
      cnt_nxt_s = load_clamp_s;
    end else if (en) begin
      if (up) begin
        // count >= L also catches a count stranded above a lowered limit.
        if (cnt_w_s < lim_w_s) begin
          cnt_nxt_s = cnt_w_s + 7'd1;
        end else if (WRAP_EN) begin
          cnt_nxt_s   = 7'd0;
          carry_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = lim_w_s;
        end
      end else begin
        if (cnt_w_s > lim_w_s) begin
          // Limit was lowered under the count: snap down to the new terminal.
          cnt_nxt_s = lim_w_s;
        end else if (cnt_w_s != 7'd0) begin
          cnt_nxt_s = cnt_w_s - 7'd1;
        end else if (WRAP_EN) begin
          cnt_nxt_s   = lim_w_s;
          carry_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = 7'd0;
        end
      end
    end else begin
      cnt_nxt_s = cnt_w_s;
    end
  end

  // Count and carry registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= RST_COUNT;
      carry_r <= 1'b0;
    end else begin
      count_r <= WIDTH'(cnt_nxt_s);
      carry_r <= carry_nxt_s;
    end
  end

  // Terminal indication for stop mode, decoded from the count register.
  always_comb begin
    done_s = 1'b0;
    if (!WRAP_EN) begin
      if (up) begin
        done_s = (cnt_w_s >= lim_w_s);
      end else begin
        done_s = (cnt_w_s == 7'd0);
      end
    end else begin
      done_s = 1'b0;
    end
  end

  assign bcd_s = bin_to_bcd(cnt_w_s);
  assign tens  = bcd_s[7:4];
  assign ones  = bcd_s[3:0];
  assign count = count_r;
  assign carry = carry_r;
  assign done  = done_s;

endmodule

// File: tb/tb_bcd_mod_counter.sv
module tb_bcd_mod_counter;

  typedef struct {
    logic [6:0] cnt;
    logic [7:0] bcd;
    logic       cy;
    logic       dn;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mism     = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // wrap-mode instance
  logic       w_en = 1'b0, w_up = 1'b0, w_load = 1'b0;
  logic [6:0] w_load_val = 7'd0, w_limit = 7'd0;
  logic [6:0] w_count;
  logic [3:0] w_tens, w_ones;
  logic       w_carry, w_done;

  // stop-mode instance
  logic       s_en = 1'b0, s_up = 1'b1, s_load = 1'b0;
  logic [6:0] s_load_val = 7'd0, s_limit = 7'd99;
  logic [6:0] s_count;
  logic [3:0] s_tens, s_ones;
  logic       s_carry, s_done;

  // two-stage chain
  logic       c0_en = 1'b0;
  logic [6:0] c_limit = 7'd59;
  logic [6:0] c0_count, c1_count;
  logic [3:0] c0_tens, c0_ones, c1_tens, c1_ones;
  logic       c0_carry, c0_done, c1_carry, c1_done;

  always #5 clk = ~clk;

  bcd_mod_counter #(.WIDTH(7), .RESET_VAL(0), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .en(w_en), .up(w_up), .load(w_load),
    .load_val(w_load_val), .limit(w_limit), .count(w_count),
    .tens(w_tens), .ones(w_ones), .carry(w_carry), .done(w_done));

  bcd_mod_counter #(.WIDTH(7), .RESET_VAL(0), .WRAP(0)) u_stop (
    .clk(clk), .rst(rst), .en(s_en), .up(s_up), .load(s_load),
    .load_val(s_load_val), .limit(s_limit), .count(s_count),
    .tens(s_tens), .ones(s_ones), .carry(s_carry), .done(s_done));

  bcd_mod_counter #(.WIDTH(7), .RESET_VAL(0), .WRAP(1)) u_c0 (
    .clk(clk), .rst(rst), .en(c0_en), .up(1'b1), .load(1'b0),
    .load_val(7'd0), .limit(c_limit), .count(c0_count),
    .tens(c0_tens), .ones(c0_ones), .carry(c0_carry), .done(c0_done));

  bcd_mod_counter #(.WIDTH(7), .RESET_VAL(0), .WRAP(1)) u_c1 (
    .clk(clk), .rst(rst), .en(c0_carry), .up(1'b1), .load(1'b0),
    .load_val(7'd0), .limit(c_limit), .count(c1_count),
    .tens(c1_tens), .ones(c1_ones), .carry(c1_carry), .done(c1_done));

  function automatic exp_t mk(input int c, input bit cy, input bit dn);
    exp_t e;
    e.cnt = 7'(c);
    e.bcd = {4'(c / 10), 4'(c % 10)};
    e.cy  = cy;
    e.dn  = dn;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    tick();
    compared += 5;
    if (w_count !== 7'd0) begin mism++; $display("FAIL reset.count: got %0d want 0", w_count); end
    if ({w_tens, w_ones} !== 8'h00) begin mism++; $display("FAIL reset.bcd: got %h want 00", {w_tens, w_ones}); end
    if (w_carry !== 1'b0) begin mism++; $display("FAIL reset.carry: got %b want 0", w_carry); end
    if (s_done !== 1'b0) begin mism++; $display("FAIL reset.done: got %b want 0", s_done); end
    if (c1_count !== 7'd0) begin mism++; $display("FAIL reset.chain: got %0d want 0", c1_count); end
    rst = 1'b0;
    // preload 37, then hit reset between edges
    w_limit = 7'd59; w_up = 1'b1; w_load = 1'b1; w_load_val = 7'd37; w_en = 1'b0;
    q.push_back(mk(37, 1'b0, 1'b0));
    tick();
    e = q.pop_front();
    compared += 2;
    if (w_count !== e.cnt) begin mism++; $display("FAIL reset.load37: got %0d want %0d", w_count, e.cnt); end
    if ({w_tens, w_ones} !== e.bcd) begin mism++; $display("FAIL reset.bcd37: got %h want %h", {w_tens, w_ones}, e.bcd); end
    w_load = 1'b0; w_en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    compared += 3;
    if (w_count !== 7'd0) begin mism++; $display("FAIL reset.async_count: got %0d want 0", w_count); end
    if ({w_tens, w_ones} !== 8'h00) begin mism++; $display("FAIL reset.async_bcd: got %h want 00", {w_tens, w_ones}); end
    if (w_carry !== 1'b0) begin mism++; $display("FAIL reset.async_carry: got %b want 0", w_carry); end
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      q.push_back(mk(i, 1'b0, 1'b0));
      tick();
      e = q.pop_front();
      compared += 2;
      if (w_count !== e.cnt) begin mism++; $display("FAIL reset.resume: got %0d want %0d", w_count, e.cnt); end
      if (w_carry !== e.cy) begin mism++; $display("FAIL reset.resume_carry: got %b want %b", w_carry, e.cy); end
    end
    w_en = 1'b0;
  endtask

  task automatic test_up_wrap();
    exp_t e;
    int   ec[5];
    bit   ey[5];
    ec = '{57, 58, 59, 0, 1};
    ey = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    w_limit = 7'd59; w_up = 1'b1; w_load = 1'b1; w_load_val = 7'd57; w_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      q.push_back(mk(ec[i], ey[i], 1'b0));
      tick();
      w_load = 1'b0;
      e = q.pop_front();
      compared += 4;
      if (w_count !== e.cnt) begin mism++; $display("FAIL up_wrap.count[%0d]: got %0d want %0d", i, w_count, e.cnt); end
      if ({w_tens, w_ones} !== e.bcd) begin mism++; $display("FAIL up_wrap.bcd[%0d]: got %h want %h", i, {w_tens, w_ones}, e.bcd); end
      if (w_carry !== e.cy) begin mism++; $display("FAIL up_wrap.carry[%0d]: got %b want %b", i, w_carry, e.cy); end
      if (w_done !== e.dn) begin mism++; $display("FAIL up_wrap.done[%0d]: got %b want %b", i, w_done, e.dn); end
    end
    w_en = 1'b0;
  endtask

  task automatic test_down_borrow();
    exp_t e;
    int   ec[6];
    bit   ey[6];
    ec = '{1, 0, 23, 22, 9, 8};
    ey = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    w_limit = 7'd23; w_up = 1'b0; w_load = 1'b1; w_load_val = 7'd1; w_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) w_limit = 7'd9;
      q.push_back(mk(ec[i], ey[i], 1'b0));
      tick();
      w_load = 1'b0; w_en = 1'b1;
      e = q.pop_front();
      compared += 3;
      if (w_count !== e.cnt) begin mism++; $display("FAIL down.count[%0d]: got %0d want %0d", i, w_count, e.cnt); end
      if ({w_tens, w_ones} !== e.bcd) begin mism++; $display("FAIL down.bcd[%0d]: got %h want %h", i, {w_tens, w_ones}, e.bcd); end
      if (w_carry !== e.cy) begin mism++; $display("FAIL down.carry[%0d]: got %b want %b", i, w_carry, e.cy); end
    end
    w_en = 1'b0;
  endtask

  task automatic test_stop_mode();
    exp_t e;
    int   ec[5];
    bit   ed[5];
    ec = '{2, 1, 0, 0, 0};
    ed = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    s_limit = 7'd99; s_up = 1'b0; s_load = 1'b1; s_load_val = 7'd2; s_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      q.push_back(mk(ec[i], 1'b0, ed[i]));
      tick();
      s_load = 1'b0; s_en = 1'b1;
      e = q.pop_front();
      compared += 4;
      if (s_count !== e.cnt) begin mism++; $display("FAIL stop.count[%0d]: got %0d want %0d", i, s_count, e.cnt); end
      if ({s_tens, s_ones} !== e.bcd) begin mism++; $display("FAIL stop.bcd[%0d]: got %h want %h", i, {s_tens, s_ones}, e.bcd); end
      if (s_carry !== e.cy) begin mism++; $display("FAIL stop.carry[%0d]: got %b want %b", i, s_carry, e.cy); end
      if (s_done !== e.dn) begin mism++; $display("FAIL stop.done[%0d]: got %b want %b", i, s_done, e.dn); end
    end
    s_up = 1'b1;
    #1;
    compared++;
    if (s_done !== 1'b0) begin mism++; $display("FAIL stop.done_dirflip: got %b want 0", s_done); end
    q.push_back(mk(1, 1'b0, 1'b0));
    tick();
    e = q.pop_front();
    compared += 3;
    if (s_count !== e.cnt) begin mism++; $display("FAIL stop.up_count: got %0d want %0d", s_count, e.cnt); end
    if (s_carry !== e.cy) begin mism++; $display("FAIL stop.up_carry: got %b want %b", s_carry, e.cy); end
    if (s_done !== e.dn) begin mism++; $display("FAIL stop.up_done: got %b want %b", s_done, e.dn); end
    s_en = 1'b0;
  endtask

  task automatic test_priority_clamp();
    exp_t e;
    int   ec[4];
    bit   ey[4];
    bit   ld[4];
    int   lv[4];
    int   lm[4];
    ec = '{45, 99, 0, 1};
    ey = '{1'b0, 1'b0, 1'b1, 1'b0};
    ld = '{1'b1, 1'b1, 1'b0, 1'b0};
    lv = '{120, 99, 0, 0};
    lm = '{45, 110, 110, 110};
    w_up = 1'b1; w_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_load = ld[i]; w_load_val = 7'(lv[i]); w_limit = 7'(lm[i]);
      q.push_back(mk(ec[i], ey[i], 1'b0));
      tick();
      e = q.pop_front();
      compared += 3;
      if (w_count !== e.cnt) begin mism++; $display("FAIL prio.count[%0d]: got %0d want %0d", i, w_count, e.cnt); end
      if ({w_tens, w_ones} !== e.bcd) begin mism++; $display("FAIL prio.bcd[%0d]: got %h want %h", i, {w_tens, w_ones}, e.bcd); end
      if (w_carry !== e.cy) begin mism++; $display("FAIL prio.carry[%0d]: got %b want %b", i, w_carry, e.cy); end
    end
    w_en = 1'b0; w_load = 1'b0;
  endtask

  task automatic test_zero_limit();
    exp_t e;
    int   ey[5];
    ey = '{0, 1, 1, 1, 0};
    w_limit = 7'd0; w_up = 1'b1; w_load = 1'b1; w_load_val = 7'd5; w_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      q.push_back(mk(0, ey[i] != 0, 1'b0));
      tick();
      w_load = 1'b0;
      w_en = (i < 3);
      e = q.pop_front();
      compared += 2;
      if (w_count !== e.cnt) begin mism++; $display("FAIL zero_lim.count[%0d]: got %0d want %0d", i, w_count, e.cnt); end
      if (w_carry !== e.cy) begin mism++; $display("FAIL zero_lim.carry[%0d]: got %b want %b", i, w_carry, e.cy); end
    end
    w_en = 1'b0;
  endtask

  task automatic test_chain();
    exp_t e;
    int   e1;
    c0_en = 1'b1;
    for (int k = 1; k <= 125; k++) begin
      e1 = (k >= 121) ? 2 : ((k >= 61) ? 1 : 0);
      q.push_back(mk(e1, 1'b0, 1'b0));
      tick();
      e = q.pop_front();
      compared += 4;
      if (c1_count !== e.cnt) begin mism++; $display("FAIL chain.c1_count@%0d: got %0d want %0d", k, c1_count, e.cnt); end
      if ({c1_tens, c1_ones} !== e.bcd) begin mism++; $display("FAIL chain.c1_bcd@%0d: got %h want %h", k, {c1_tens, c1_ones}, e.bcd); end
      if (c0_count !== 7'(k % 60)) begin mism++; $display("FAIL chain.c0_count@%0d: got %0d want %0d", k, c0_count, k % 60); end
      if (c0_carry !== ((k % 60) == 0)) begin mism++; $display("FAIL chain.c0_carry@%0d: got %b want %b", k, c0_carry, (k % 60) == 0); end
    end
    c0_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_borrow();
    test_stop_mode();
    test_priority_clamp();
    test_zero_limit();
    test_chain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
